pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 134 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer between pipeline stages.
// The main entry drives out_*; the skid entry catches the single transfer
// that arrives in the cycle downstream stalls, so in_ready can be a flop.
// Optional feature macro: PIPE_SKID_STATS_EN adds stall_cnt / flush_cnt.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A source holding valid=1 keeps its payload stable until it sees
// ready=1. in_ready is registered and never depends on out_ready.
// The FSM state is visible on occ (EMPTY=0, ONE=1, FULL=2).
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic accept;
  logic emit;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  // Bubble gating: downstream sees a NOP whenever nothing is presented.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign occ       = state;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Payload steering: where (if anywhere) each entry loads from this edge.
  assign load_main_in   = !flush && accept &&
                          ((state == ST_EMPTY) || ((state == ST_ONE) && emit));
  assign load_main_skid = !flush && (state == ST_FULL) && emit;
  assign load_skid      = !flush && accept && (state == ST_ONE) && !emit;

  // Next-state decode; flush wins over accept and emit.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !emit)      state_nxt = ST_FULL;
          else if (!accept && emit) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (emit) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register and registered ready (ready whenever not FULL next cycle).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  // Entry storage; flush zeroes control so a stale instruction cannot leak.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // Saturating event counters: downstream stall cycles and effective flushes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && (state != ST_EMPTY) && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random stimulus against a queue model of
// an in-order two-slot buffer with registered ready.
module tb_pipe_skid_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;

  logic              clk;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occ;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
  int                stall_m;
  int                flush_m;
`endif

  // Model: queue of {ctrl, data} held by the buffer, oldest first.
  logic [CTRL_W+DATA_W-1:0] exp_q[$];
  int n_assert;
  int n_fail;

  pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occ       (occ)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    chk("occ", 48'(occ), 48'(n));
    chk("in_ready", 48'(in_ready), 48'(n < 2));
    chk("out_valid", 48'(out_valid), 48'(n != 0));
    if (n != 0) begin
      chk("out_data", 48'(out_data), 48'(exp_q[0][DATA_W-1:0]));
      chk("out_ctrl", 48'(out_ctrl), 48'(exp_q[0][CTRL_W+DATA_W-1:DATA_W]));
    end else begin
      chk("out_ctrl_bubble", 48'(out_ctrl), 48'h0);
    end
`ifdef PIPE_SKID_STATS_EN
    chk("stall_cnt", 48'(stall_cnt), 48'(stall_m));
    chk("flush_cnt", 48'(flush_cnt), 48'(flush_m));
`endif
  endtask

  // One clock: check presented outputs, advance the model, cross the edge.
  task automatic cycle();
    int n;
    bit acc;
    bit emi;
    check_outputs();
    n   = exp_q.size();
    acc = in_valid && (n < 2);
    emi = (n != 0) && out_ready;
`ifdef PIPE_SKID_STATS_EN
    if (n != 0 && !out_ready && stall_m < 65535) stall_m++;
    if (flush && n != 0 && flush_m < 65535) flush_m++;
`endif
    if (flush) begin
      exp_q.delete();
    end else begin
      if (emi) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Stimulus, scoreboard and report.
  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef PIPE_SKID_STATS_EN
    stall_m = 0;
    flush_m = 0;
`endif
    clr = 1'b1;
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    #3;
    chk("reset_out_data", 48'(out_data), 48'h0);
    check_outputs();
    @(negedge clk);
    clr = 1'b0;

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 16'(i + 16'h100), 1'b1, 1'b0);
      cycle();
      chk("stream_occ", 48'(occ), 48'h1);
    end
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Backpressure A, B
    drive(1'b1, 32'hA, 16'h0A0A, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hB, 16'h0B0B, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    chk("bp_full_occ", 48'(occ), 48'h2);
    chk("bp_full_ready", 48'(in_ready), 48'h0);
    chk("bp_hold_data", 48'(out_data), 48'hA);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle();
    chk("bp_drain1_data", 48'(out_data), 48'hB);
    cycle();
    chk("bp_drain2_occ", 48'(occ), 48'h0);
    cycle();

    // Flush while FULL with a same-cycle 0xC offered
    drive(1'b1, 32'h11, 16'h1111, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h22, 16'h2222, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hC, 16'h0C0C, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("flush_occ", 48'(occ), 48'h0);
    chk("flush_valid", 48'(out_valid), 48'h0);
    chk("flush_ctrl", 48'(out_ctrl), 48'h0);
    cycle();
    cycle();

    // Async reset between edges while FULL
    drive(1'b1, 32'h33, 16'h3333, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h44, 16'h4444, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    cycle();
    #2;
    clr = 1'b1;
    #1;
    chk("areset_valid", 48'(out_valid), 48'h0);
    chk("areset_ready", 48'(in_ready), 48'h1);
    chk("areset_occ", 48'(occ), 48'h0);
    chk("areset_ctrl", 48'(out_ctrl), 48'h0);
    chk("areset_data", 48'(out_data), 48'h0);
    exp_q.delete();
`ifdef PIPE_SKID_STATS_EN
    stall_m = 0;
    flush_m = 0;
`endif
    @(posedge clk);
    #3;
    clr = 1'b0;
    // First accept on the first edge after release
    drive(1'b1, 32'h55, 16'h5555, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("post_reset_accept", 48'(out_data), 48'h55);
    cycle();

    // Bubble: no valid input, ctrl all ones
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD, 16'hFFFF, 1'(i[0]), 1'b0);
      cycle();
      chk("bubble_valid", 48'(out_valid), 48'h0);
      chk("bubble_ctrl", 48'(out_ctrl), 48'h0);
    end

`ifdef PIPE_SKID_STATS_EN
    // Stats: five stall cycles with occ=1, then one flush
    drive(1'b1, 32'h66, 16'h6666, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("stats_stall5", 48'(stall_cnt), 48'(stall_m));
    chk("stats_stall_abs", 48'(stall_cnt), 48'(stall_m - 5 + 5));
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("stats_flush1", 48'(flush_cnt), 48'(flush_m));
    cycle();
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      cycle();
    end
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
